// File: rtl/muldiv_seq_pkg.sv
// ============================================================================
// Module : rv32i_types (package)
// Brief  : Shared RV32M operation codes and muldiv sequencer state encoding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rv32i_types;

   typedef enum logic [2:0] {
      MUL    = 3'b000,
      MULH   = 3'b001,
      MULHSU = 3'b010,
      MULHU  = 3'b011,
      DIV    = 3'b100,
      DIVU   = 3'b101,
      REM    = 3'b110,
      REMU   = 3'b111
   } muldiv_funct3_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } muldiv_state_t;

   function automatic logic op_a_signed(input muldiv_funct3_t f);
      return !(f == MULHU || f == DIVU || f == REMU);
   endfunction

   function automatic logic op_b_signed(input muldiv_funct3_t f);
      return (f == MUL || f == MULH || f == DIV || f == REM);
   endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_seq_if.sv
// ============================================================================
// Module : muldiv_seq_if
// Brief  : Execute-stage request/response bundle for the muldiv sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface muldiv_seq_if
   import rv32i_types::*;
   #(parameter int XLEN = 32);

   logic            start;
   logic            flush;
   muldiv_funct3_t  funct3;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (output start, flush, funct3, a, b, input stall, done, result);
   modport slave  (input start, flush, funct3, a, b, output stall, done, result);

endinterface

`default_nettype wire

// File: rtl/muldiv_datapath.sv
// ============================================================================
// Module : muldiv_datapath
// Brief  : Shared shift register plus 33-bit adder/subtractor for the
//          shift-add multiply and restoring divide loops.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module muldiv_datapath #(
   parameter int XLEN = 32
) (
   input  wire logic            clk,
   input  wire logic            rst,
   input  wire logic            i_init,
   input  wire logic            i_step,
   input  wire logic            i_is_div,
   input  wire logic [XLEN-1:0] i_init_lo,
   input  wire logic [XLEN-1:0] i_init_op,
   output      logic [XLEN-1:0] o_nxt_hi,
   output      logic [XLEN-1:0] o_nxt_lo
);

   // hi:lo holds product (multiply) or remainder:quotient (divide)
   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;
   logic [XLEN-1:0] r_op;
   logic [XLEN:0]   w_lhs;
   logic [XLEN:0]   w_rhs;
   logic [XLEN:0]   w_sum;

   assign w_lhs = i_is_div ? {r_hi, r_lo[XLEN-1]} : {1'b0, r_hi};
   assign w_rhs = {1'b0, r_op};
   assign w_sum = i_is_div ? (w_lhs - w_rhs) : (w_lhs + w_rhs);

   // Partial remainder stays below 2*divisor, so bit XLEN of the difference is the borrow
   always_comb begin
      o_nxt_hi = r_hi;
      o_nxt_lo = r_lo;
      if (i_is_div) begin
         o_nxt_hi = w_sum[XLEN] ? w_lhs[XLEN-1:0] : w_sum[XLEN-1:0];
         o_nxt_lo = {r_lo[XLEN-2:0], ~w_sum[XLEN]};
      end else if (r_lo[0]) begin
         {o_nxt_hi, o_nxt_lo} = {w_sum, r_lo[XLEN-1:1]};
      end else begin
         {o_nxt_hi, o_nxt_lo} = {1'b0, r_hi, r_lo[XLEN-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hi <= '0;
         r_lo <= '0;
         r_op <= '0;
      end else if (i_init) begin
         r_hi <= '0;
         r_lo <= i_init_lo;
         r_op <= i_init_op;
      end else if (i_step) begin
         r_hi <= o_nxt_hi;
         r_lo <= o_nxt_lo;
      end
   end

endmodule

`default_nettype wire

// File: rtl/muldiv_seq.sv
// ============================================================================
// Module : muldiv_seq
// Brief  : Iterative RV32M multiply/divide sequencer with pipeline stall,
//          sign fixup and RISC-V divide corner cases.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module muldiv_seq
   import rv32i_types::*;
#(
   parameter int XLEN = 32
) (
   input wire logic    clk,
   input wire logic    rst,
   muldiv_seq_if.slave bus
);

   localparam int              CW     = $clog2(XLEN);
   localparam logic [CW-1:0]   c_last = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] c_min  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] c_ones = '1;

   muldiv_state_t   r_state;
   logic [CW-1:0]   r_count;
   muldiv_funct3_t  r_funct3;
   logic            r_neg_q;
   logic            r_neg_r;
   logic            r_done;
   logic [XLEN-1:0] r_result;

   logic            w_sa;
   logic            w_sb;
   logic [XLEN-1:0] w_abs_a;
   logic [XLEN-1:0] w_abs_b;
   logic            w_is_div;
   logic            w_div0;
   logic            w_ovf;
   logic [XLEN-1:0] w_special_res;
   logic            w_accept;
   logic [XLEN-1:0] w_nxt_hi;
   logic [XLEN-1:0] w_nxt_lo;
   logic [2*XLEN-1:0] w_prod;
   logic [XLEN-1:0] w_quo;
   logic [XLEN-1:0] w_rem;
   logic [XLEN-1:0] w_final;

   assign w_sa     = op_a_signed(bus.funct3) & bus.a[XLEN-1];
   assign w_sb     = op_b_signed(bus.funct3) & bus.b[XLEN-1];
   assign w_abs_a  = w_sa ? -bus.a : bus.a;
   assign w_abs_b  = w_sb ? -bus.b : bus.b;
   assign w_is_div = bus.funct3[2];
   assign w_div0   = w_is_div && (bus.b == '0);
   assign w_ovf    = w_is_div && op_b_signed(bus.funct3) && (bus.a == c_min) && (bus.b == c_ones);

   // funct3[1] separates rem/remu from div/divu
   always_comb begin
      w_special_res = '0;
      if (w_div0)
         w_special_res = bus.funct3[1] ? bus.a : c_ones;
      else if (w_ovf)
         w_special_res = bus.funct3[1] ? '0 : c_min;
   end

   assign w_accept  = (r_state == IDLE) && bus.start && !bus.flush;
   assign bus.stall = w_accept || (r_state == CALC);
   assign bus.done   = r_done;
   assign bus.result = r_result;

   muldiv_datapath #(.XLEN(XLEN)) u_datapath (
      .clk       (clk),
      .rst       (rst),
      .i_init    (w_accept),
      .i_step    ((r_state == CALC) && !bus.flush),
      .i_is_div  (r_funct3[2]),
      .i_init_lo (w_is_div ? w_abs_a : w_abs_b),
      .i_init_op (w_is_div ? w_abs_b : w_abs_a),
      .o_nxt_hi  (w_nxt_hi),
      .o_nxt_lo  (w_nxt_lo)
   );

   // Fixup works on the post-step values so the result lands in the DONE register directly
   assign w_prod = r_neg_q ? -{w_nxt_hi, w_nxt_lo} : {w_nxt_hi, w_nxt_lo};
   assign w_quo  = r_neg_q ? -w_nxt_lo : w_nxt_lo;
   assign w_rem  = r_neg_r ? -w_nxt_hi : w_nxt_hi;

   always_comb begin
      case (r_funct3)
         MUL:                 w_final = w_prod[XLEN-1:0];
         MULH, MULHSU, MULHU: w_final = w_prod[2*XLEN-1:XLEN];
         DIV, DIVU:           w_final = w_quo;
         default:             w_final = w_rem;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_funct3 <= MUL;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_done   <= 1'b0;
         r_result <= '0;
         if (bus.flush) begin
            r_state <= IDLE;
            r_count <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (bus.start) begin
                     r_funct3 <= bus.funct3;
                     r_neg_q  <= w_sa ^ w_sb;
                     r_neg_r  <= w_sa;
                     r_count  <= '0;
                     if (w_div0 || w_ovf) begin
                        r_state  <= DONE;
                        r_done   <= 1'b1;
                        r_result <= w_special_res;
                     end else begin
                        r_state <= CALC;
                     end
                  end
               end
               CALC: begin
                  r_count <= r_count + 1'b1;
                  if (r_count == c_last) begin
                     r_state  <= DONE;
                     r_done   <= 1'b1;
                     r_result <= w_final;
                  end
               end
               DONE:    r_state <= IDLE;
               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// ============================================================================
// Module : tb_muldiv_seq
// Brief  : Directed self-checking bench for muldiv_seq.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_seq;
   import rv32i_types::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total  = 0;
   int   passed = 0;
   int   cycles = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cycles <= cycles + 1;

   muldiv_seq_if #(.XLEN(32)) bus ();

   muldiv_seq #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   // Issues one op at the next edge and follows it until done or a cycle budget expires
   task automatic run_op(input string tag, input muldiv_funct3_t f, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] exp, input int lat,
                         output int done_at);
      int   cyc;
      logic stall_ok;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.funct3 = f; bus.a = av; bus.b = bv;
      cyc = 0; stall_ok = 1'b1; done_at = -1;
      forever begin
         @(negedge clk);
         if (bus.done === 1'b1) break;
         if (bus.stall !== 1'b1) stall_ok = 1'b0;
         if (cyc > 40) break;
         @(posedge clk); #1;
         bus.start = 1'b0;
         cyc++;
      end
      done_at = cycles;
      chk({tag, " latency"}, 32'(cyc), 32'(lat));
      chk({tag, " result"}, bus.result, exp);
      chk({tag, " stall"}, {31'b0, stall_ok}, 32'd1);
      chk({tag, " stall@done"}, {31'b0, bus.stall}, 32'd0);
   endtask

   initial begin
      int t0, t1, npulse;
      bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = MUL; bus.a = '0; bus.b = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset stall", {31'b0, bus.stall}, 32'd0);
      chk("reset done", {31'b0, bus.done}, 32'd0);
      chk("reset result", bus.result, 32'd0);

      run_op("mul", MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, t0);
      run_op("mulh", MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, t0);
      run_op("mulhsu", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, t0);
      run_op("mulhu", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, t0);
      run_op("div", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, t0);
      run_op("rem", REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, t0);
      run_op("divu", DIVU, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 33, t0);
      run_op("remu", REMU, 32'hFFFFFFF9, 32'd2, 32'h00000001, 33, t0);
      run_op("mul big", MUL, 32'd12345, 32'd6789, 32'd83810205, 33, t0);
      run_op("divu big", DIVU, 32'd1000000, 32'd7, 32'd142857, 33, t0);

      run_op("divu by0", DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1, t0);
      run_op("rem by0", REM, 32'd5, 32'd0, 32'd5, 1, t0);
      run_op("div ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, t0);
      run_op("rem ovf", REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, t0);

      // flush in cycle 10 of a multiply
      @(posedge clk); #1;
      bus.start = 1'b1; bus.funct3 = MUL; bus.a = 32'd3; bus.b = 32'd5;
      repeat (10) begin @(posedge clk); #1; bus.start = 1'b0; end
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      @(negedge clk);
      chk("flush stall", {31'b0, bus.stall}, 32'd0);
      chk("flush done", {31'b0, bus.done}, 32'd0);
      run_op("after flush", MUL, 32'd9, 32'd11, 32'd99, 33, t0);

      // start held through DONE
      @(posedge clk); #1;
      bus.start = 1'b1; bus.funct3 = MUL; bus.a = 32'd2; bus.b = 32'd3;
      npulse = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) npulse++;
         @(posedge clk); #1;
         if (i >= 33) bus.start = 1'b0;
      end
      chk("held start pulses", 32'(npulse), 32'd1);

      run_op("b2b first", MUL, 32'd4, 32'd5, 32'd20, 33, t0);
      run_op("b2b second", MUL, 32'd6, 32'd7, 32'd42, 33, t1);
      chk("b2b interval", 32'(t1 - t0), 32'd34);

      // reset mid-CALC
      @(posedge clk); #1;
      bus.start = 1'b1; bus.funct3 = DIV; bus.a = 32'd100; bus.b = 32'd7;
      repeat (5) begin @(posedge clk); #1; bus.start = 1'b0; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst stall", {31'b0, bus.stall}, 32'd0);
      chk("rst done", {31'b0, bus.done}, 32'd0);
      chk("rst result", bus.result, 32'd0);
      run_op("after rst", REMU, 32'd100, 32'd7, 32'd2, 33, t0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
